// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// geometry defaults, derived field widths and the controller state encoding.
package dcache_pkg;

  localparam int DEF_LINES     = 16;
  localparam int DEF_LINE_BITS = 256;
  localparam int OFFS_W        = 5;
  localparam int IDX_W         = $clog2(DEF_LINES);
  localparam int TAG_W         = 32 - OFFS_W - IDX_W;
  localparam int WORDS         = DEF_LINE_BITS / 32;
  localparam int WSEL_W        = $clog2(WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RF   = 2'd2,
    ST_UPD  = 2'd3
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache.
// Reads are asynchronous; writes happen on the clock edge, either a full
// refill line (marks the line valid and clean) or a single store word
// (marks the line dirty). Only the flag bits are cleared by reset.
module dcache_sram import dcache_pkg::*; #(
  parameter int LINES     = DEF_LINES,
  parameter int LINE_BITS = DEF_LINE_BITS,
  parameter int IDX       = IDX_W,
  parameter int TAG       = TAG_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX-1:0]       rdIdx,
  output logic                 rdValid,
  output logic                 rdDirty,
  output logic [TAG-1:0]       rdTag,
  output logic [LINE_BITS-1:0] rdLine,
  input  logic                 lineWe,
  input  logic [IDX-1:0]       lineIdx,
  input  logic [TAG-1:0]       lineTag,
  input  logic [LINE_BITS-1:0] lineData,
  input  logic                 wordWe,
  input  logic [IDX-1:0]       wordIdx,
  input  logic [WSEL_W-1:0]    wordSel,
  input  logic [31:0]          wordData
);

  logic [LINES-1:0]     valid_r;
  logic [LINES-1:0]     dirty_r;
  logic [TAG-1:0]       tag_r  [LINES];
  logic [LINE_BITS-1:0] data_r [LINES];

  assign rdValid = valid_r[rdIdx];
  assign rdDirty = dirty_r[rdIdx];
  assign rdTag   = tag_r[rdIdx];
  assign rdLine  = data_r[rdIdx];

  // Line state flags: cleared by reset, set clean by a refill, dirtied by a store.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (lineWe) begin
      valid_r[lineIdx] <= 1'b1;
      dirty_r[lineIdx] <= 1'b0;
    end else if (wordWe) begin
      dirty_r[wordIdx] <= 1'b1;
    end
  end

  // Tag and data storage: refill replaces the whole line, a store patches one word.
  always_ff @(posedge clk_i) begin
    if (lineWe) begin
      tag_r[lineIdx]  <= lineTag;
      data_r[lineIdx] <= lineData;
    end else if (wordWe) begin
      data_r[wordIdx][{wordSel, 5'b00000} +: 32] <= wordData;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. Hits complete with zero stall; misses freeze the pipeline while
// an optional victim write-back and a line refill run over the req/ack bus.
module dcache_ctrl import dcache_pkg::*; #(
  parameter int LINES     = DEF_LINES,
  parameter int LINE_BITS = DEF_LINE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_rdata_i
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = 32 - OFFS_W - IDX;

  state_e               curState_r;
  state_e               nextState_s;
  logic [IDX-1:0]       idx_s;
  logic [TAG-1:0]       tag_s;
  logic [WSEL_W-1:0]    wsel_s;
  logic                 vValid_s;
  logic                 vDirty_s;
  logic [TAG-1:0]       vTag_s;
  logic [LINE_BITS-1:0] vLine_s;
  logic                 hit_s;
  logic                 miss_s;
  logic                 lineWe_s;
  logic                 wordWe_s;
  logic [IDX-1:0]       missIdx_r;
  logic [TAG-1:0]       missTag_r;
  logic [LINE_BITS-1:0] refill_r;
  logic                 unusedAddr_s;

  assign idx_s        = cpu_addr_i[OFFS_W+IDX-1:OFFS_W];
  assign tag_s        = cpu_addr_i[31:OFFS_W+IDX];
  assign wsel_s       = cpu_addr_i[OFFS_W-1:2];
  assign unusedAddr_s = ^cpu_addr_i[1:0];

  // Hits are only recognised in IDLE; other states are busy with a miss.
  assign hit_s  = cpu_req_i & vValid_s & (vTag_s == tag_s) & (curState_r == ST_IDLE);
  assign miss_s = cpu_req_i & ~hit_s & (curState_r == ST_IDLE);

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .IDX       (IDX),
    .TAG       (TAG)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rdIdx    (idx_s),
    .rdValid  (vValid_s),
    .rdDirty  (vDirty_s),
    .rdTag    (vTag_s),
    .rdLine   (vLine_s),
    .lineWe   (lineWe_s),
    .lineIdx  (missIdx_r),
    .lineTag  (missTag_r),
    .lineData (refill_r),
    .wordWe   (wordWe_s),
    .wordIdx  (idx_s),
    .wordSel  (wsel_s),
    .wordData (cpu_wdata_i)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      curState_r <= ST_IDLE;
    end else begin
      curState_r <= nextState_s;
    end
  end

  // Next-state logic: write back a dirty victim first, then refill, then install.
  always_comb begin
    nextState_s = curState_r;
    case (curState_r)
      ST_IDLE: begin
        if (miss_s) begin
          nextState_s = (vValid_s & vDirty_s) ? ST_WB : ST_RF;
        end else begin
          nextState_s = ST_IDLE;
        end
      end
      ST_WB: begin
        if (mem_ack_i) begin
          nextState_s = ST_RF;
        end else begin
          nextState_s = ST_WB;
        end
      end
      ST_RF: begin
        if (mem_ack_i) begin
          nextState_s = ST_UPD;
        end else begin
          nextState_s = ST_RF;
        end
      end
      ST_UPD:  nextState_s = ST_IDLE;
      default: nextState_s = ST_IDLE;
    endcase
  end

  // CPU-side outputs and array write strobes; everything is quiet while reset is held.
  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_rdata_o = 32'h0000_0000;
    lineWe_s    = 1'b0;
    wordWe_s    = 1'b0;
    if (rst_i) begin
      cpu_stall_o = 1'b0;
    end else begin
      case (curState_r)
        ST_IDLE: begin
          cpu_stall_o = miss_s;
          wordWe_s    = hit_s & cpu_we_i;
          if (hit_s & ~cpu_we_i) begin
            cpu_rdata_o = vLine_s[{wsel_s, 5'b00000} +: 32];
          end else begin
            cpu_rdata_o = 32'h0000_0000;
          end
        end
        ST_WB, ST_RF: begin
          cpu_stall_o = 1'b1;
        end
        ST_UPD: begin
          cpu_stall_o = 1'b1;
          lineWe_s    = 1'b1;
        end
        default: begin
          cpu_stall_o = 1'b0;
        end
      endcase
    end
  end

  // Memory-bus registers: loaded on entry to WB/RF and held for the whole transfer;
  // the miss address is latched so a dropped request cannot corrupt the refill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0000_0000;
      mem_wdata_o <= {LINE_BITS{1'b0}};
      missIdx_r   <= {IDX{1'b0}};
      missTag_r   <= {TAG{1'b0}};
      refill_r    <= {LINE_BITS{1'b0}};
    end else begin
      case (curState_r)
        ST_IDLE: begin
          if (miss_s) begin
            missIdx_r <= idx_s;
            missTag_r <= tag_s;
            mem_req_o <= 1'b1;
            if (vValid_s & vDirty_s) begin
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {vTag_s, idx_s, 5'b00000};
              mem_wdata_o <= vLine_s;
            end else begin
              mem_we_o   <= 1'b0;
              mem_addr_o <= {tag_s, idx_s, 5'b00000};
            end
          end else begin
            mem_req_o <= 1'b0;
          end
        end
        ST_WB: begin
          if (mem_ack_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= {missTag_r, missIdx_r, 5'b00000};
          end
        end
        ST_RF: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            refill_r  <= mem_rdata_i;
          end
        end
        ST_UPD: begin
          mem_req_o <= 1'b0;
        end
        default: begin
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl with a line-granular backing memory and
// a word-granular reference model of what the CPU should observe.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [255:0] mem_rdata_i;

  int           nChecks = 0;
  int           nFails  = 0;
  logic [255:0] memLines [0:127];
  logic [31:0]  refMem   [0:1023];
  int           wbCnt = 0;
  int           rfCnt = 0;
  logic [31:0]  lastWbAddr;
  logic [31:0]  lastRfAddr;
  logic [255:0] lastWbLine;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access; plays the memory side (write-back delay d1, refill delay d2,
  // counted in request-high cycles including the ack cycle) until the stall clears.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d1, input int d2, output logic [31:0] rdata, output int stallCyc);
    int           reqCyc;
    logic [31:0]  tAddr;
    logic         tWe;
    logic [255:0] tWdata;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    mem_ack_i   = 1'b0;
    #1;
    stallCyc = 0;
    reqCyc   = 0;
    tAddr    = 32'h0;
    tWe      = 1'b0;
    tWdata   = 256'h0;
    while (cpu_stall_o && stallCyc < 200) begin
      if (mem_req_o) begin
        reqCyc++;
        if (reqCyc == 1) begin
          tAddr  = mem_addr_o;
          tWe    = mem_we_o;
          tWdata = mem_wdata_o;
          check("memAddrAlign", mem_addr_o[4:0], 5'd0);
        end else begin
          check("memAddrWeStable", {mem_we_o, mem_addr_o}, {tWe, tAddr});
          if (tWe) check("memWdataStable", mem_wdata_o, tWdata);
        end
        if (reqCyc == (tWe ? d1 : d2)) begin
          mem_ack_i = 1'b1;
          if (tWe) begin
            memLines[tAddr[11:5]] = mem_wdata_o;
            wbCnt++;
            lastWbAddr = tAddr;
            lastWbLine = mem_wdata_o;
          end else begin
            mem_rdata_i = memLines[tAddr[11:5]];
            rfCnt++;
            lastRfAddr = tAddr;
          end
          reqCyc = 0;
        end
      end
      stallCyc++;
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      #1;
    end
    check("stallCleared", cpu_stall_o, 1'b0);
    rdata = cpu_rdata_o;
    if (we) refMem[addr[11:2]] = wdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] expv;
    logic [9:0]  wv;
    logic [31:0] raddr;
    logic        rwe;
    logic [31:0] rdat;
    int          sc;
    int          wb0;
    int          rf0;

    for (int w = 0; w < 1024; w++) begin
      wv = w[9:0];
      refMem[w] = {16'hC0DE, 6'b000000, wv};
      memLines[w >> 3][(w % 8) * 32 +: 32] = {16'hC0DE, 6'b000000, wv};
    end
    memLines[2][31:0] = 32'hDEAD_BEEF;
    refMem[16]        = 32'hDEAD_BEEF;

    rst_i       = 1'b1;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 256'h0;
    repeat (2) @(negedge clk_i);
    #1;
    check("rstStall", cpu_stall_o, 1'b0);
    check("rstRdata", cpu_rdata_o, 32'h0);
    check("rstMemReq", mem_req_o, 1'b0);
    check("rstMemWe", mem_we_o, 1'b0);
    check("rstMemAddr", mem_addr_o, 32'h0);
    check("rstMemWdata", mem_wdata_o, 256'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // 1: cold load, refill only, 7 stall cycles
    access(1'b0, 32'h0000_0040, 32'h0, 1, 5, rd, sc);
    check("s1Stall", sc, 7);
    check("s1Rdata", rd, 32'hDEAD_BEEF);
    check("s1Wb", wbCnt, 0);
    check("s1Rf", rfCnt, 1);
    check("s1RfAddr", lastRfAddr, 32'h0000_0040);

    // 2: store hit then load of the same word in the next cycle
    access(1'b1, 32'h0000_0044, 32'h1234_5678, 1, 1, rd, sc);
    check("s2StoreStall", sc, 0);
    check("s2StoreRdata", rd, 32'h0);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 1, rd, sc);
    check("s2LoadStall", sc, 0);
    check("s2LoadRdata", rd, 32'h1234_5678);

    // 3: conflicting load evicts the dirty line
    wb0 = wbCnt;
    expv = refMem[32'h240 >> 2];
    access(1'b0, 32'h0000_0240, 32'h0, 3, 2, rd, sc);
    check("s3Stall", sc, 7);
    check("s3WbCount", wbCnt, wb0 + 1);
    check("s3WbAddr", lastWbAddr, 32'h0000_0040);
    check("s3WbWord1", lastWbLine[63:32], 32'h1234_5678);
    check("s3RfAddr", lastRfAddr, 32'h0000_0240);
    check("s3Rdata", rd, expv);
    wb0 = wbCnt;
    access(1'b0, 32'h0000_0044, 32'h0, 1, 4, rd, sc);
    check("s3CleanNoWb", wbCnt, wb0);
    check("s3BackStall", sc, 6);
    check("s3BackRdata", rd, 32'h1234_5678);

    // 4: stray ack in IDLE is ignored
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b1;
    #1;
    check("s4MemReq", mem_req_o, 1'b0);
    check("s4Stall", cpu_stall_o, 1'b0);
    check("s4Rdata", cpu_rdata_o, 32'h0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    check("s4MemReqAfter", mem_req_o, 1'b0);
    access(1'b0, 32'h0000_0044, 32'h0, 1, 1, rd, sc);
    check("s4HitStall", sc, 0);
    check("s4HitRdata", rd, 32'h1234_5678);

    // 5: reset in the middle of a refill
    @(negedge clk_i);
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0000_0080;
    #1;
    check("s5ReqStall", cpu_stall_o, 1'b1);
    @(negedge clk_i);
    #1;
    check("s5RfReq", mem_req_o, 1'b1);
    check("s5RfAddr", mem_addr_o, 32'h0000_0080);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("s5RstMemReq", mem_req_o, 1'b0);
    check("s5RstStall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    rst_i     = 1'b0;
    cpu_req_i = 1'b0;
    rf0 = rfCnt;
    access(1'b0, 32'h0000_0080, 32'h0, 1, 2, rd, sc);
    check("s5MissAgainStall", sc, 4);
    check("s5MissAgainRf", rfCnt, rf0 + 1);
    check("s5Rdata", rd, refMem[32]);

    // 6: random traffic over 4 KB against the reference model
    for (int i = 0; i < 80; i++) begin
      raddr = {20'h00000, 10'($urandom_range(0, 1023)), 2'b00};
      rwe   = 1'($urandom_range(0, 1));
      rdat  = $urandom;
      expv  = refMem[raddr[11:2]];
      access(rwe, raddr, rdat, $urandom_range(1, 20), $urandom_range(1, 20), rd, sc);
      if (!rwe) check("s6Load", rd, expv);
    end

    @(negedge clk_i);
    cpu_req_i = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
